apb_master_module: RTL
======================

APB_MASTER_MODULE -- requirements
Module: apb_master_module

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, lane width in bits.
REQ-002 SHALL have parameter BUS_WIDTH, default 64, APB data bus width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase length in cycles (legal range 2..255).
REQ-005 SHALL derive localparam STRB_WIDTH = BUS_WIDTH/DATA_WIDTH, one strobe bit per DATA_WIDTH lane.
REQ-006 SHALL use one clock and an asynchronous, active-high reset; no other clock or reset inputs.
REQ-007 clk_i  input  1  rising-edge clock.
REQ-008 rst_i  input  1  asynchronous active-high reset.
REQ-009 req_valid_i  input  1  command present.
REQ-010 req_ready_o  output  1  command accepted when high together with req_valid_i.
REQ-011 req_write_i  input  1  1 = write, 0 = read.
REQ-012 req_addr_i  input  ADDR_WIDTH  command address.
REQ-013 req_wdata_i  input  BUS_WIDTH  write data.
REQ-014 req_strb_i  input  STRB_WIDTH  write lane enables.
REQ-015 resp_valid_o  output  1  one-cycle completion pulse.
REQ-016 resp_rdata_o  output  BUS_WIDTH  read data, valid with resp_valid_o.
REQ-017 resp_err_o  output  1  slave error or timeout, valid with resp_valid_o.
REQ-018 psel_o, penable_o, pwrite_o  output  1 each  APB control.
REQ-019 paddr_o  output  ADDR_WIDTH; pwdata_o  output  BUS_WIDTH; pstrb_o  output  STRB_WIDTH.
REQ-020 pready_i, pslverr_i  input  1 each; prdata_i  input  BUS_WIDTH.
REQ-021 busy_o  output  1  high from SETUP through ACCESS.

Function
REQ-022 SHALL implement states IDLE, SETUP, ACCESS; all APB and resp outputs registered.
REQ-023 req_ready_o SHALL be high exactly when state is IDLE.
REQ-024 IDLE with req_valid_i=1: SHALL capture command, go to SETUP next cycle; else stay IDLE.
REQ-025 SETUP: psel_o=1, penable_o=0, busy_o=1; SHALL always go to ACCESS after one cycle.
REQ-026 ACCESS: psel_o=1, penable_o=1, busy_o=1; paddr_o, pwrite_o, pwdata_o, pstrb_o stable from SETUP to end of ACCESS.
REQ-027 Read commands SHALL drive pstrb_o=0 and pwdata_o=0 regardless of req_strb_i/req_wdata_i.
REQ-028 Write with req_strb_i=0 SHALL still be issued unchanged.
REQ-029 ACCESS with pready_i=1: SHALL go IDLE, pulse resp_valid_o next cycle, resp_err_o=pslverr_i, resp_rdata_o=prdata_i for reads and 0 for writes.
REQ-030 ACCESS with pready_i=0: SHALL increment wait counter, stay in ACCESS.
REQ-031 If pready_i=0 in the TIMEOUT_CYCLES-th ACCESS cycle: SHALL go IDLE, pulse resp_valid_o with resp_err_o=1, resp_rdata_o=0.
REQ-032 Wait counter SHALL clear on entry to SETUP; counter width 8 bits.
REQ-033 On return to IDLE: psel_o=0, penable_o=0 same cycle as resp_valid_o; a command presented then SHALL be accepted (SETUP follows next cycle).
REQ-034 Minimum latency: accept at cycle N, SETUP N+1, ACCESS N+2, resp_valid_o N+3 with zero wait states.
REQ-035 resp_rdata_o and resp_err_o SHALL hold last value until next resp_valid_o.

Reset
REQ-036 rst_i=1 SHALL immediately force IDLE and all outputs to 0 except req_ready_o=1.
REQ-037 Reset during SETUP or ACCESS SHALL abort the transfer with no resp_valid_o pulse.
REQ-038 After rst_i deasserts, first command SHALL be accepted on the first rising edge with req_valid_i=1.

Verification
REQ-039 Write 0x10, wdata 0x1111_2222_3333_4444, strb 2'b11, pready_i=1 -> psel N+1, penable N+2, resp_valid N+3, resp_err=0.
REQ-040 Read 0x10, prdata_i=0xDEAD_BEEF_0000_0001, 2 wait states -> ACCESS 3 cycles, pstrb_o=0, resp_rdata=0xDEAD_BEEF_0000_0001.
REQ-041 Read with pslverr_i=1 at pready_i=1 -> resp_err_o=1, resp_valid_o single pulse.
REQ-042 pready_i held 0, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then resp_err_o=1, resp_rdata_o=0, psel_o=0.
REQ-043 req_valid_i held high, 3 commands -> each accepted in IDLE cycle coinciding with prior resp_valid_o; 3 cycles per command.
REQ-044 rst_i pulsed mid-ACCESS -> psel_o/penable_o 0 immediately, no resp_valid_o, req_ready_o=1.

Source files
------------

// File: rtl/apb_master_module.sv
// APB master: turns one valid/ready command into a SETUP/ACCESS transfer and returns
// a single-cycle response pulse. ACCESS phases that run too long are closed with an error.
//
// state  | meaning
// IDLE   | waiting for a command, req_ready_o high
// SETUP  | psel asserted, address/control presented for one cycle
// ACCESS | penable asserted, waiting for pready_i or the wait limit
module apb_master_module #(
    parameter int DATA_WIDTH     = 32,
    parameter int BUS_WIDTH      = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int STRB_WIDTH    = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [BUS_WIDTH-1:0]  req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_strb_i,
    output logic                  resp_valid_o,
    output logic [BUS_WIDTH-1:0]  resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Wait count of the final permitted ACCESS cycle (count starts at 0 in the first one)
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  busy_q, busy_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [BUS_WIDTH-1:0]  resp_rdata_q, resp_rdata_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            busy_q       <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            busy_q       <= busy_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        busy_d       = busy_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d    = SETUP;
                    wait_cnt_d = '0;
                    psel_d     = 1'b1;
                    busy_d     = 1'b1;
                    pwrite_d   = req_write_i;
                    paddr_d    = req_addr_i;
                    // Reads never expose stale write data or lane enables on the bus
                    pwdata_d   = req_write_i ? req_wdata_i : '0;
                    pstrb_d    = req_write_i ? req_strb_i  : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready_i || (wait_cnt_q == WAIT_LAST)) begin
                    state_d      = IDLE;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    busy_d       = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = pready_i ? pslverr_i : 1'b1;
                    resp_rdata_d = (pready_i && !pwrite_q) ? prdata_i : '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;
    assign psel_o       = psel_q;
    assign penable_o    = penable_q;
    assign busy_o       = busy_q;
    assign pwrite_o     = pwrite_q;
    assign paddr_o      = paddr_q;
    assign pwdata_o     = pwdata_q;
    assign pstrb_o      = pstrb_q;

endmodule
